// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO on the OTTER I/O bus.
// Define UART_TX_IRQ_EN to generate the transmit-complete IRQ pulse; otherwise IRQ is 0.
module iobus_uart_tx #(
  parameter logic [31:0] DATA_AD    = 32'h11180000,
  parameter logic [31:0] STATUS_AD  = 32'h111C0000,
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        IRQ
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf, full, empty;
  logic          push_req, push, pop, clr;
  logic [7:0]    shreg, shreg_nx;
  logic [BW-1:0] baud, baud_nx;
  logic [2:0]    bitn, bitn_nx;
  logic          tx_nx, done;
  logic [31:0]   status;
  logic          unused;

  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign push_req = IOBUS_WR && IOBUS_ADDR == DATA_AD;
  assign clr      = IOBUS_WR && IOBUS_ADDR == STATUS_AD
                    && IOBUS_OUT[2];
  assign pop      = state == IDLE && !empty;
  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign push     = push_req && (!full || pop);
  assign done     = baud == BAUD_LAST;
  assign unused   = ^{IOBUS_OUT[31:8]};

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= IOBUS_OUT[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push_req && !push) ovf <= 1'b1;
      else if (clr)          ovf <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    baud_nx  = '0;
    bitn_nx  = bitn;
    tx_nx    = TX;
    if (state != IDLE) baud_nx = done ? '0 : baud + BW'(1);
    unique case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (!empty) begin
          shreg_nx = mem[rd_ptr];
          state_nx = START;
          tx_nx    = 1'b0;
        end
      end
      START: begin
        if (done) begin
          state_nx = DATA;
          bitn_nx  = '0;
          tx_nx    = shreg[0];
        end
      end
      DATA: begin
        if (done) begin
          if (bitn == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            shreg_nx = {1'b0, shreg[7:1]};
            bitn_nx  = bitn + 3'd1;
            tx_nx    = shreg[1];
          end
        end
      end
      STOP: begin
        tx_nx = 1'b1;
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // TX is registered from the next-state value so it changes on the state edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      shreg <= '0;
      baud  <= '0;
      bitn  <= '0;
      TX    <= 1'b1;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      baud  <= baud_nx;
      bitn  <= bitn_nx;
      TX    <= tx_nx;
    end
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge CLK) begin
    if (RESET) IRQ <= 1'b0;
    else       IRQ <= state == STOP && done && empty;
  end
`else
  assign IRQ = 1'b0;
`endif

  assign status = {8'h00, 8'(count), 8'h00, 4'h0,
                   state != IDLE, ovf, empty, !full};
  assign IOBUS_IN = (IOBUS_ADDR == STATUS_AD) ? status : '0;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// tb_iobus_uart_tx: self-checking bench for iobus_uart_tx (DIV=10, 4-entry FIFO).
// A behavioural UART receiver and frame-waveform model provide the expected line data.
module tb_iobus_uart_tx;
  localparam logic [31:0] DATA_AD   = 32'h11180000;
  localparam logic [31:0] STATUS_AD = 32'h111C0000;
  localparam int DIV = 10;

  typedef struct {
    int   k;
    logic tx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_s = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] dout = '0;
  logic [31:0] din;
  logic        tx, irq;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   irq_cnt = 0;
  int   irq_last = -1;
  bit   mon_en = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit   ref_q[$];
  logic wave [0:400];
  vec_t tv [13];

  iobus_uart_tx #(
    .DATA_AD(DATA_AD), .STATUS_AD(STATUS_AD),
    .CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(4)
  ) dut (
    .CLK(clk), .RESET(rst), .IOBUS_ADDR(addr),
    .IOBUS_OUT(dout), .IOBUS_WR(wr_s), .IOBUS_IN(din),
    .TX(tx), .IRQ(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      irq_cnt++;
      irq_last = cyc;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act, exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h",
                  nm, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, d);
    addr = a; dout = d; wr_s = 1'b1;
    tick();
    wr_s = 1'b0; addr = '0; dout = '0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] v);
    addr = a;
    #1;
    v = din;
    addr = '0;
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] v;
    int t = 0;
    rd(STATUS_AD, v);
    while (v !== 32'h3 && t < 3000) begin
      tick();
      rd(STATUS_AD, v);
      t++;
    end
    chk(nm, v, 32'h3);
  endtask

  // reference line waveform: start, 8 data LSB first, stop, one idle cycle
  task automatic ref_frame(input logic [7:0] b);
    repeat (DIV) ref_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      repeat (DIV) ref_q.push_back(b[i]);
    repeat (DIV) ref_q.push_back(1'b1);
    ref_q.push_back(1'b1);
  endtask

  task automatic cmp_wave(input string nm, input int n);
    int bad = 0;
    int first = -1;
    for (int k = 1; k <= n; k++) begin
      logic e;
      e = (k - 1 < ref_q.size()) ? ref_q[k-1] : 1'b1;
      if (wave[k] !== e) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    if (bad != 0) $display("  %s first difference at k=%0d", nm, first);
    chk(nm, bad, 0);
  endtask

  task automatic chk_rx(input string nm);
    chk({nm, "_n"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", nm, i),
          (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD,
          {24'h0, exp_q[i]});
  endtask

  initial begin : rx_mon
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    b = '0;
    forever begin
      @(posedge clk);
      #2;
      if (prev === 1'b1 && tx === 1'b0) begin
        repeat (DIV / 2) @(posedge clk);
        #2;
        if (mon_en) chk("rx_start", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #2;
          b[i] = tx;
        end
        repeat (DIV) @(posedge clk);
        #2;
        if (mon_en) begin
          chk("rx_stop", tx, 1);
          rx_q.push_back(b);
        end
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] v, d;
    int n0, i0, t, bad;

    tv = '{'{0, 1'b1}, '{1, 1'b0}, '{10, 1'b0}, '{11, 1'b1},
           '{20, 1'b1}, '{21, 1'b0}, '{31, 1'b1}, '{45, 1'b0},
           '{81, 1'b0}, '{90, 1'b0}, '{91, 1'b1}, '{100, 1'b1},
           '{101, 1'b1}};

    tick(3);
    rst = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    rd(STATUS_AD, v);
    chk("rst_status", v, 32'h3);
    rd(DATA_AD, v);
    chk("rd_data_ad", v, 0);
    rd(32'h0, v);
    chk("rd_other_ad", v, 0);

    // single byte 0x55; upper data bits must be ignored
    rx_q.delete(); exp_q.delete(); ref_q.delete();
    bus_wr(DATA_AD, 32'hABCD_0055);
    wave[0] = tx;
    for (int k = 1; k <= 102; k++) begin
      tick();
      wave[k] = tx;
      if (k == 101) begin
        rd(STATUS_AD, v);
        chk("t1_status_end", v, 32'h3);
      end
    end
    for (int i = 0; i < 13; i++)
      chk($sformatf("t1_tx_k%0d", tv[i].k),
          wave[tv[i].k], tv[i].tx);
    ref_frame(8'h55);
    cmp_wave("t1_wave", 102);
    exp_q.push_back(8'h55);
    chk_rx("t1_rx");

    // fill and overflow, then overflow clear
    rx_q.delete(); exp_q.delete();
    for (int i = 1; i <= 6; i++) bus_wr(DATA_AD, i);
    rd(STATUS_AD, v);
    chk("t2_status_full", v, 32'h0004_000C);
    bus_wr(STATUS_AD, 32'h0);
    rd(STATUS_AD, v);
    chk("t3_clr0_keep", v, 32'h0004_000C);
    bus_wr(STATUS_AD, 32'hFFFF_FFFB);
    rd(STATUS_AD, v);
    chk("t3_other_bits_keep", v, 32'h0004_000C);
    bus_wr(STATUS_AD, 32'h4);
    rd(STATUS_AD, v);
    chk("t3_clr", v, 32'h0004_0008);
    wait_idle("t2_drain");
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    chk_rx("t2_rx");

    // back-to-back frames
    rx_q.delete(); exp_q.delete(); ref_q.delete();
    bus_wr(DATA_AD, 32'hA5);
    wave[0] = tx;
    addr = DATA_AD; dout = 32'h3C; wr_s = 1'b1;
    tick();
    wave[1] = tx;
    wr_s = 1'b0; addr = '0; dout = '0;
    for (int k = 2; k <= 203; k++) begin
      tick();
      wave[k] = tx;
    end
    ref_frame(8'hA5);
    ref_frame(8'h3C);
    cmp_wave("t4_wave", 203);
    chk("t4_stop_k100", wave[100], 1);
    chk("t4_gap_k101", wave[101], 1);
    chk("t4_start_k102", wave[102], 0);
    chk("t4_stop_k201", wave[201], 1);
    wait_idle("t4_drain");
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    chk_rx("t4_rx");

    // transmit-complete IRQ over three queued bytes
    rx_q.delete(); exp_q.delete();
    i0 = irq_cnt;
    bus_wr(DATA_AD, 32'h11);
    n0 = cyc;
    bus_wr(DATA_AD, 32'h22);
    bus_wr(DATA_AD, 32'h33);
    tick(320);
`ifdef UART_TX_IRQ_EN
    chk("t6_irq_count", irq_cnt - i0, 1);
    chk("t6_irq_cycle", irq_last - n0, 303);
`else
    chk("t6_irq_none", irq_cnt, 0);
`endif
    wait_idle("t6_drain");
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    chk_rx("t6_rx");

    // randomized traffic, firmware-style polling for space
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      tick($urandom_range(0, 60));
      t = 0;
      rd(STATUS_AD, v);
      while (v[0] !== 1'b1 && t < 2000) begin
        tick();
        rd(STATUS_AD, v);
        t++;
      end
      d = $urandom;
      bus_wr(DATA_AD, d);
      exp_q.push_back(d[7:0]);
    end
    wait_idle("rand_drain");
    chk_rx("rand_rx");

    // reset during bit 3 of 0xFF with two bytes queued
    mon_en = 1'b0;
    bus_wr(DATA_AD, 32'hFF);
    n0 = cyc;
    bus_wr(DATA_AD, 32'h11);
    bus_wr(DATA_AD, 32'h22);
    tick(42);
    rd(STATUS_AD, v);
    chk("t5_status_pre", v, 32'h0002_0009);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_reset_edge", cyc - n0, 45);
    chk("t5_tx", tx, 1);
    chk("t5_irq", irq, 0);
    rd(STATUS_AD, v);
    chk("t5_status", v, 32'h3);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    chk("t5_quiet", bad, 0);
    rd(STATUS_AD, v);
    chk("t5_status_end", v, 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
